// File: rtl/if_pipe_pkg.sv
// Shared encodings and field positions for the instruction-fetch stage.
package if_pipe_pkg;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [4:0]  XZR    = 5'd31;
  localparam int          RN_LSB = 5;
  localparam int          RN_MSB = 9;
  localparam int          RM_LSB = 16;
  localparam int          RM_MSB = 20;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;
endpackage

// File: rtl/if_pipe_if.sv
// Fetch-stage bus: imem word, redirect, ID/EX hazard inputs and IF/ID outputs.
interface if_pipe_if;
  logic [31:0] imem_instr_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        ex_memRead_in;
  logic [4:0]  ex_write_register_in;
  logic [31:0] pc_fetch_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic        bubble_out;
  logic [31:0] stall_count_out;
  logic [15:0] flush_count_out;

  modport master (
    output imem_instr_in, branch_taken_in, branch_target_in,
           ex_memRead_in, ex_write_register_in,
    input  pc_fetch_out, pc_out, instr_out, valid_out, bubble_out,
           stall_count_out, flush_count_out
  );

  modport slave (
    input  imem_instr_in, branch_taken_in, branch_target_in,
           ex_memRead_in, ex_write_register_in,
    output pc_fetch_out, pc_out, instr_out, valid_out, bubble_out,
           stall_count_out, flush_count_out
  );
endinterface

// File: rtl/if_pipe_hazard_unit.sv
// Load-use detector; only active when IF_PIPE_HAZARD_DETECT_EN is defined,
// otherwise software is expected to schedule the NOPs and stall is tied low.
module hazard_unit
  import if_pipe_pkg::*;
(
  input  logic       valid,
  input  logic       mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] rn,
  input  logic [4:0] rm,
  output logic       stall
);
`ifdef IF_PIPE_HAZARD_DETECT_EN
  // XZR never carries a produced value, so a load into it cannot hazard
  assign stall = valid && mem_read && (ex_rd != XZR) &&
                 ((ex_rd == rn) || (ex_rd == rm));
`else
  logic unused_hz;
  assign unused_hz = ^{valid, mem_read, ex_rd, rn, rm};
  assign stall     = 1'b0;
`endif
endmodule

// File: rtl/if_pipe.sv
// Instruction fetch stage: PC, IF/ID register, stall/flush counters.
// Load-use stalling is compiled in with IF_PIPE_HAZARD_DETECT_EN.
module if_pipe
  import if_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic      CLK,
  input  logic      RESET,
  if_pipe_if.slave  bus
);
  logic [31:0] pc;
  ifid_t       ifid;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        stall;
  logic        bubble;
  logic        unused_tgt;

  hazard_unit u_hazard (
    .valid    (ifid.valid),
    .mem_read (bus.ex_memRead_in),
    .ex_rd    (bus.ex_write_register_in),
    .rn       (ifid.instr[RN_MSB:RN_LSB]),
    .rm       (ifid.instr[RM_MSB:RM_LSB]),
    .stall    (stall)
  );

  // a taken branch squashes the stalled instruction, so no bubble is needed
  assign bubble     = stall && !bus.branch_taken_in;
  assign unused_tgt = ^bus.branch_target_in[1:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc        <= RESET_PC;
      ifid      <= '{pc: 32'h0, instr: NOP, valid: 1'b0};
      stall_cnt <= 32'h0;
      flush_cnt <= 16'h0;
    end else begin
      if (bus.branch_taken_in) begin
        pc   <= {bus.branch_target_in[31:2], 2'b00};
        ifid <= '{pc: 32'h0, instr: NOP, valid: 1'b0};
        if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      end else if (!stall) begin
        pc   <= pc + PC_INC;
        ifid <= '{pc: pc, instr: bus.imem_instr_in, valid: 1'b1};
      end
      if (bubble) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.pc_fetch_out    = pc;
  assign bus.pc_out          = ifid.pc;
  assign bus.instr_out       = ifid.instr;
  assign bus.valid_out       = ifid.valid;
  assign bus.bubble_out      = bubble;
  assign bus.stall_count_out = stall_cnt;
  assign bus.flush_count_out = flush_cnt;
endmodule
